axi_s_buf: RTL and testbench

Single-clock, parametrised AXI slave-side buffer. It sits between the AXI crossbar's slave port and a slave IP in the same clock domain. It decouples all five channels with per-channel synchronous FIFOs of configurable depth. It can also cap the number of outstanding read and write bursts accepted from the bus.

---
 rtl/axi_s_buf_if.sv | 91 +++++++++
 rtl/axi_s_buf.sv | 202 ++++++++++++++++++++
 tb/tb_axi_s_buf.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_s_buf_if.sv
// AXI channel bundle shared by the bus-side and IP-side ports of axi_s_buf.
// Field widths come from the AXI_*_BITS macros, with defaults when they are not predefined.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

interface axi_s_buf_if;
    localparam int unsigned ID_W    = `AXI_IDS_BITS;
    localparam int unsigned ADDR_W  = `AXI_ADDR_BITS;
    localparam int unsigned LEN_W   = `AXI_LEN_BITS;
    localparam int unsigned SIZE_W  = `AXI_SIZE_BITS;
    localparam int unsigned DATA_W  = `AXI_DATA_BITS;
    localparam int unsigned STRB_W  = `AXI_STRB_BITS;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    logic [ID_W-1:0]    awid;
    logic [ADDR_W-1:0]  awaddr;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;
    logic [BURST_W-1:0] awburst;
    logic               awvalid;
    logic               awready;

    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;

    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic               arvalid;
    logic               arready;

    logic [ID_W-1:0]    rid;
    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    logic [ID_W-1:0]    bid;
    logic [RESP_W-1:0]  bresp;
    logic               bvalid;
    logic               bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_s_buf.sv
// AXI slave-side buffer: one synchronous FIFO per channel plus outstanding-burst counters.
// Define AXI_S_BUF_OSTD_LIMIT_EN to gate AW/AR acceptance by MAX_OSTD outstanding bursts.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_s_buf #(
    parameter int unsigned AW_DEPTH = 2,
    parameter int unsigned W_DEPTH  = 4,
    parameter int unsigned AR_DEPTH = 2,
    parameter int unsigned R_DEPTH  = 4,
    parameter int unsigned B_DEPTH  = 2,
    parameter int unsigned MAX_OSTD = 4,
    localparam int unsigned OW      = $clog2(MAX_OSTD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    axi_s_buf_if.slave    axi,
    axi_s_buf_if.master   ip,
    output logic [OW-1:0] wr_ostd,
    output logic [OW-1:0] rd_ostd
);
    localparam int unsigned ID_W   = `AXI_IDS_BITS;
    localparam int unsigned ADDR_W = `AXI_ADDR_BITS;
    localparam int unsigned LEN_W  = `AXI_LEN_BITS;
    localparam int unsigned SIZE_W = `AXI_SIZE_BITS;
    localparam int unsigned DATA_W = `AXI_DATA_BITS;
    localparam int unsigned STRB_W = `AXI_STRB_BITS;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
        logic [1:0]        burst;
    } ax_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_t;

    ax_t  aw_in, aw_out, ar_in, ar_out;
    w_t   w_in, w_out;
    r_t   r_in, r_out;
    b_t   b_in, b_out;
    logic aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
    logic r_full, r_empty, b_full, b_empty;
    logic aw_push, aw_pop, w_push, w_pop, ar_push, ar_pop;
    logic r_push, r_pop, b_push, b_pop;
    logic aw_cap_ok, ar_cap_ok;

`ifdef AXI_S_BUF_OSTD_LIMIT_EN
    assign aw_cap_ok = (wr_ostd < OW'(MAX_OSTD));
    assign ar_cap_ok = (rd_ostd < OW'(MAX_OSTD));
`else
    assign aw_cap_ok = 1'b1;
    assign ar_cap_ok = 1'b1;
`endif

    // Producer READY and consumer VALID derive only from registered FIFO/counter state.
    assign axi.awready = ~aw_full & aw_cap_ok;
    assign axi.wready  = ~w_full;
    assign axi.arready = ~ar_full & ar_cap_ok;
    assign ip.rready   = ~r_full;
    assign ip.bready   = ~b_full;

    assign ip.awvalid  = ~aw_empty;
    assign ip.wvalid   = ~w_empty;
    assign ip.arvalid  = ~ar_empty;
    assign axi.rvalid  = ~r_empty;
    assign axi.bvalid  = ~b_empty;

    assign aw_push = axi.awvalid & axi.awready;
    assign w_push  = axi.wvalid  & axi.wready;
    assign ar_push = axi.arvalid & axi.arready;
    assign r_push  = ip.rvalid   & ip.rready;
    assign b_push  = ip.bvalid   & ip.bready;

    assign aw_pop  = ip.awvalid  & ip.awready;
    assign w_pop   = ip.wvalid   & ip.wready;
    assign ar_pop  = ip.arvalid  & ip.arready;
    assign r_pop   = axi.rvalid  & axi.rready;
    assign b_pop   = axi.bvalid  & axi.bready;

    assign aw_in = {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst};
    assign w_in  = {axi.wdata, axi.wstrb, axi.wlast};
    assign ar_in = {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst};
    assign r_in  = {ip.rid, ip.rdata, ip.rresp, ip.rlast};
    assign b_in  = {ip.bid, ip.bresp};

    assign {ip.awid, ip.awaddr, ip.awlen, ip.awsize, ip.awburst} = aw_out;
    assign {ip.wdata, ip.wstrb, ip.wlast}                        = w_out;
    assign {ip.arid, ip.araddr, ip.arlen, ip.arsize, ip.arburst} = ar_out;
    assign {axi.rid, axi.rdata, axi.rresp, axi.rlast}            = r_out;
    assign {axi.bid, axi.bresp}                                  = b_out;

    axi_s_buf_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk(clk), .rst(rst), .push(aw_push), .din(aw_in), .pop(aw_pop),
        .dout_c(aw_out), .full_c(aw_full), .empty_c(aw_empty));

    axi_s_buf_fifo #(.WIDTH($bits(w_t)), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk(clk), .rst(rst), .push(w_push), .din(w_in), .pop(w_pop),
        .dout_c(w_out), .full_c(w_full), .empty_c(w_empty));

    axi_s_buf_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AR_DEPTH)) u_ar_fifo (
        .clk(clk), .rst(rst), .push(ar_push), .din(ar_in), .pop(ar_pop),
        .dout_c(ar_out), .full_c(ar_full), .empty_c(ar_empty));

    axi_s_buf_fifo #(.WIDTH($bits(r_t)), .DEPTH(R_DEPTH)) u_r_fifo (
        .clk(clk), .rst(rst), .push(r_push), .din(r_in), .pop(r_pop),
        .dout_c(r_out), .full_c(r_full), .empty_c(r_empty));

    axi_s_buf_fifo #(.WIDTH($bits(b_t)), .DEPTH(B_DEPTH)) u_b_fifo (
        .clk(clk), .rst(rst), .push(b_push), .din(b_in), .pop(b_pop),
        .dout_c(b_out), .full_c(b_full), .empty_c(b_empty));

    // Simultaneous inc/dec cancels; decrement at zero (protocol error) holds at zero.
    function automatic logic [OW-1:0] ostd_next(logic [OW-1:0] cur, logic inc, logic dec);
        if (inc && !dec && cur != '1) return cur + OW'(1);
        if (dec && !inc && cur != '0) return cur - OW'(1);
        return cur;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ostd <= '0;
            rd_ostd <= '0;
        end else begin
            wr_ostd <= ostd_next(wr_ostd, aw_push, b_pop);
            rd_ostd <= ostd_next(rd_ostd, ar_push, r_pop & axi.rlast);
        end
    end
endmodule

// Synchronous FIFO with extra-MSB pointers; head entry is read straight from memory.
module axi_s_buf_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout_c,
    output logic             full_c,
    output logic             empty_c
);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = PW + 1;

    logic [PTR_W-1:0] wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + PTR_W'(1);
            if (pop)  rp <= rp + PTR_W'(1);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wp[PW-1:0]] <= din;
    end

    assign full_c  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign empty_c = (wp == rp);
    assign dout_c  = mem[rp[PW-1:0]];
endmodule

// File: tb/tb_axi_s_buf.sv
// Bench for axi_s_buf: per-channel scoreboards plus a cycle table for the read path.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module tb_axi_s_buf;
`ifdef AXI_S_BUF_OSTD_LIMIT_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] wr_ostd, rd_ostd;
    int         n_cmp = 0;
    int         n_err = 0;

    axi_s_buf_if bus ();
    axi_s_buf_if ip ();

    axi_s_buf dut (
        .clk(clk), .rst(rst), .axi(bus), .ip(ip),
        .wr_ostd(wr_ostd), .rd_ostd(rd_ostd)
    );

    always #5 clk = ~clk;

    logic [127:0] aw_q[$], w_q[$], ar_q[$], r_q[$], b_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic sb_chk(input string name, input bit have, input logic [127:0] act,
                          input logic [127:0] exp);
        if (!have) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %0h want <nothing queued>", name, act);
        end else begin
            chk(name, act, exp);
        end
    endtask

    // Score the handshakes of the coming edge (pops before pushes), then advance one cycle.
    task automatic step();
        logic [127:0] e;
        bit h;
        if (rst) begin
            aw_q.delete(); w_q.delete(); ar_q.delete(); r_q.delete(); b_q.delete();
        end else begin
            if (ip.awvalid && ip.awready) begin
                h = aw_q.size() != 0; e = h ? aw_q.pop_front() : '0;
                sb_chk("aw_payload", h, 128'({ip.awid, ip.awaddr, ip.awlen, ip.awsize, ip.awburst}), e);
            end
            if (ip.wvalid && ip.wready) begin
                h = w_q.size() != 0; e = h ? w_q.pop_front() : '0;
                sb_chk("w_payload", h, 128'({ip.wdata, ip.wstrb, ip.wlast}), e);
            end
            if (ip.arvalid && ip.arready) begin
                h = ar_q.size() != 0; e = h ? ar_q.pop_front() : '0;
                sb_chk("ar_payload", h, 128'({ip.arid, ip.araddr, ip.arlen, ip.arsize, ip.arburst}), e);
            end
            if (bus.rvalid && bus.rready) begin
                h = r_q.size() != 0; e = h ? r_q.pop_front() : '0;
                sb_chk("r_payload", h, 128'({bus.rid, bus.rdata, bus.rresp, bus.rlast}), e);
            end
            if (bus.bvalid && bus.bready) begin
                h = b_q.size() != 0; e = h ? b_q.pop_front() : '0;
                sb_chk("b_payload", h, 128'({bus.bid, bus.bresp}), e);
            end
            if (bus.awvalid && bus.awready)
                aw_q.push_back(128'({bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst}));
            if (bus.wvalid && bus.wready)
                w_q.push_back(128'({bus.wdata, bus.wstrb, bus.wlast}));
            if (bus.arvalid && bus.arready)
                ar_q.push_back(128'({bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst}));
            if (ip.rvalid && ip.rready)
                r_q.push_back(128'({ip.rid, ip.rdata, ip.rresp, ip.rlast}));
            if (ip.bvalid && ip.bready)
                b_q.push_back(128'({ip.bid, ip.bresp}));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit         arv;
        bit         rv;
        bit         rl;
        bit         rr;
        logic [2:0] exp_ostd;
        bit         exp_rvalid;
    } rvec_t;

    rvec_t tbl[13];

    initial begin
        // Read-path cycle table: AR accepts, IP R beats, bus RREADY -> rd_ostd and RVALID_AXI.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};

        rst = 1'b1;
        bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
        bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
        bus.arsize = '0; bus.arburst = '0;
        bus.rready = 1'b1; bus.bready = 1'b1;
        ip.awready = 1'b1; ip.wready = 1'b1; ip.arready = 1'b1;
        ip.rvalid = 1'b0; ip.rid = '0; ip.rdata = '0; ip.rresp = '0; ip.rlast = 1'b0;
        ip.bvalid = 1'b0; ip.bid = '0; ip.bresp = '0;
        @(negedge clk);

        // Reset then idle
        step(); step();
        chk("rst_awvalid", 128'(ip.awvalid), 128'(0));
        chk("rst_wvalid", 128'(ip.wvalid), 128'(0));
        chk("rst_arvalid", 128'(ip.arvalid), 128'(0));
        chk("rst_rvalid_axi", 128'(bus.rvalid), 128'(0));
        chk("rst_bvalid_axi", 128'(bus.bvalid), 128'(0));
        chk("rst_awready_axi", 128'(bus.awready), 128'(1));
        chk("rst_wready_axi", 128'(bus.wready), 128'(1));
        chk("rst_arready_axi", 128'(bus.arready), 128'(1));
        chk("rst_rready", 128'(ip.rready), 128'(1));
        chk("rst_bready", 128'(ip.bready), 128'(1));
        chk("rst_wr_ostd", 128'(wr_ostd), 128'(0));
        chk("rst_rd_ostd", 128'(rd_ostd), 128'(0));
        rst = 1'b0;
        step();

        // Read-path table
        for (int i = 0; i < 13; i++) begin
            bus.arvalid = tbl[i].arv;
            bus.arid = 8'(8'h20 + i); bus.araddr = $urandom; bus.arlen = 8'(i);
            bus.arsize = 3'(i); bus.arburst = 2'(i);
            ip.rvalid = tbl[i].rv; ip.rlast = tbl[i].rl;
            ip.rid = 8'(8'h30 + i); ip.rdata = $urandom; ip.rresp = 2'(i);
            bus.rready = tbl[i].rr;
            step();
            chk($sformatf("tbl%0d_rd_ostd", i), 128'(rd_ostd), 128'(tbl[i].exp_ostd));
            chk($sformatf("tbl%0d_rvalid", i), 128'(bus.rvalid), 128'(tbl[i].exp_rvalid));
        end
        bus.arvalid = 1'b0; ip.rvalid = 1'b0; ip.rlast = 1'b0; bus.rready = 1'b1;
        step();

        // Single write: AW, four W beats, then B
        bus.awvalid = 1'b1; bus.awid = 8'h12; bus.awaddr = 32'h1000_0000;
        bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awburst = 2'd1;
        chk("wr_awready", 128'(bus.awready), 128'(1));
        step();
        bus.awvalid = 1'b0;
        chk("wr_awvalid_n1", 128'(ip.awvalid), 128'(1));
        chk("wr_awid", 128'(ip.awid), 128'(8'h12));
        chk("wr_awaddr", 128'(ip.awaddr), 128'(32'h1000_0000));
        chk("wr_awlen", 128'(ip.awlen), 128'(3));
        chk("wr_ostd_up", 128'(wr_ostd), 128'(1));
        step();
        chk("wr_awvalid_drained", 128'(ip.awvalid), 128'(0));
        for (int i = 0; i < 4; i++) begin
            bus.wvalid = 1'b1; bus.wdata = 32'hD000_0000 + 32'(i);
            bus.wstrb = 4'(4'hF - i); bus.wlast = (i == 3);
            step();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        step(); step();
        chk("wr_w_drained", 128'(w_q.size()), 128'(0));
        ip.bvalid = 1'b1; ip.bid = 8'h12; ip.bresp = 2'd0; bus.bready = 1'b0;
        chk("wr_bvalid_before", 128'(bus.bvalid), 128'(0));
        step();
        ip.bvalid = 1'b0;
        chk("wr_bvalid_n1", 128'(bus.bvalid), 128'(1));
        chk("wr_bid", 128'(bus.bid), 128'(8'h12));
        chk("wr_bresp", 128'(bus.bresp), 128'(0));
        chk("wr_ostd_held", 128'(wr_ostd), 128'(1));
        bus.bready = 1'b1;
        step();
        chk("wr_bvalid_done", 128'(bus.bvalid), 128'(0));
        chk("wr_ostd_down", 128'(wr_ostd), 128'(0));

        // W FIFO full with slave stalled
        ip.wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wvalid = 1'b1; bus.wdata = 32'hA0 + 32'(i); bus.wstrb = 4'hF; bus.wlast = (i == 3);
            chk($sformatf("wf_wready_%0d", i), 128'(bus.wready), 128'(1));
            step();
        end
        bus.wdata = 32'hA4; bus.wlast = 1'b1;
        chk("wf_wready_full", 128'(bus.wready), 128'(0));
        chk("wf_wvalid", 128'(ip.wvalid), 128'(1));
        ip.wready = 1'b1;
        step();
        ip.wready = 1'b0;
        chk("wf_wready_after_pop", 128'(bus.wready), 128'(1));
        step();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        chk("wf_wready_refull", 128'(bus.wready), 128'(0));
        ip.wready = 1'b1;
        repeat (5) step();
        chk("wf_all_beats_out", 128'(w_q.size()), 128'(0));
        chk("wf_wvalid_empty", 128'(ip.wvalid), 128'(0));

        // Outstanding read cap
        for (int i = 0; i < 5; i++) begin
            bus.arvalid = 1'b1; bus.arid = 8'(8'h40 + i); bus.araddr = 32'h2000_0000 + 32'(i * 16);
            bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'd1;
            chk($sformatf("cap_arready_%0d", i), 128'(bus.arready), 128'((CAP && i >= 4) ? 0 : 1));
            step();
            chk($sformatf("cap_rd_ostd_%0d", i), 128'(rd_ostd), 128'((CAP && i >= 4) ? 4 : i + 1));
        end
        if (!CAP) bus.arvalid = 1'b0;
        ip.rvalid = 1'b1; ip.rlast = 1'b1; ip.rid = 8'h40; ip.rdata = 32'hCAFE_0001; ip.rresp = 2'd0;
        step();
        ip.rvalid = 1'b0; ip.rlast = 1'b0;
        chk("cap_arready_held", 128'(bus.arready), 128'(CAP ? 0 : 1));
        chk("cap_rvalid", 128'(bus.rvalid), 128'(1));
        step();
        chk("cap_rd_ostd_dec", 128'(rd_ostd), 128'(CAP ? 3 : 4));
        chk("cap_arready_back", 128'(bus.arready), 128'(1));
        step();
        bus.arvalid = 1'b0;
        chk("cap_rd_ostd_refill", 128'(rd_ostd), 128'(4));
        chk("cap_arready_refill", 128'(bus.arready), 128'(CAP ? 0 : 1));

        // Reset in the middle of an R burst
        ip.rvalid = 1'b1; ip.rlast = 1'b0; ip.rid = 8'h55; ip.rdata = 32'h5000;
        step();
        ip.rdata = 32'h5001;
        step();
        chk("mr_rvalid_b1", 128'(bus.rvalid), 128'(1));
        ip.rdata = 32'h5002; rst = 1'b1;
        step();
        rst = 1'b0; ip.rvalid = 1'b0;
        chk("mr_rvalid", 128'(bus.rvalid), 128'(0));
        chk("mr_rd_ostd", 128'(rd_ostd), 128'(0));
        chk("mr_rready", 128'(ip.rready), 128'(1));
        chk("mr_wr_ostd", 128'(wr_ostd), 128'(0));
        step();
        chk("mr_rvalid_after", 128'(bus.rvalid), 128'(0));
        chk("end_queues_empty",
            128'(aw_q.size() + w_q.size() + ar_q.size() + r_q.size() + b_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
